// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory port (combinational read, write on posedge)
// between the pipeline MEM stage (CPU) and a debug/loader master. The CPU has
// priority. A debug request that has been refused MAX_WAIT cycles in a row is
// granted anyway, and that grant opens a burst of up to BURST debug beats
// during which the CPU is stalled.
//
// Ports
//   clk_i          clock, all state on posedge
//   rst_ni         asynchronous active-low reset
//   cpu_re_i       MEM-stage load
//   cpu_we_i       MEM-stage store
//   cpu_addr_i     MEM-stage byte address
//   cpu_wdata_i    store data
//   cpu_rdata_o    load data (straight from mem_rdata_i)
//   cpu_stall_o    CPU access not performed this cycle; MEM must hold
//   dbg_valid_i    debug request valid, fields stable until accepted
//   dbg_we_i       debug request is a write (1) or a read (0)
//   dbg_addr_i     debug byte address
//   dbg_wdata_i    debug write data
//   dbg_ready_o    debug request accepted this cycle
//   dbg_rvalid_o   debug read data valid, one cycle after the read beat
//   dbg_rdata_o    registered debug read data
//   mem_we_o       dmem write enable
//   mem_addr_o     dmem address
//   mem_wdata_o    dmem write data
//   mem_rdata_i    dmem combinational read data
//   dbg_owner_o    high while a forced debug burst owns the port
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8,
    parameter int BURST    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpu_re_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_stall_o,
    input  logic          dbg_valid_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_wdata_i,
    output logic          dbg_ready_o,
    output logic          dbg_rvalid_o,
    output logic [DW-1:0] dbg_rdata_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          dbg_owner_o
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST + 1);

    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST);
    localparam logic [BW-1:0] BEAT_ONE = BW'(1);

    // A one-beat burst is complete after the forcing beat itself.
    localparam bit BURST_MULTI = (BURST > 1);

    typedef enum logic {
        S_CPU = 1'b0,
        S_DBG = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            rvalid_q;
    logic [DW-1:0]   rdata_q;

    logic            cpu_req;
    logic            wait_full;
    logic            grant_dbg;
    logic            forced;
    logic            read_beat;

    assign cpu_req   = cpu_re_i | cpu_we_i;
    assign wait_full = (wait_q == WAIT_MAX);
    // Opportunistic grant when the CPU is quiet, forced grant once starved.
    assign grant_dbg = (state_q == S_CPU) & dbg_valid_i & (~cpu_req | wait_full);
    assign forced    = grant_dbg & cpu_req;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_CPU;
            wait_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        case (state_q)
            S_CPU: begin
                if (grant_dbg || !dbg_valid_i) begin
                    wait_d = '0;
                end else if (!wait_full) begin
                    wait_d = wait_q + WAIT_ONE;
                end
                if (forced && BURST_MULTI) begin
                    state_d = S_DBG;
                    beat_d  = BEAT_ONE;
                end
            end
            S_DBG: begin
                wait_d = '0;
                // Leave when the master goes quiet or this beat fills the burst.
                if (!dbg_valid_i || ((beat_q + BEAT_ONE) == BEAT_MAX)) begin
                    state_d = S_CPU;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end
            default: begin
                state_d = S_CPU;
                wait_d  = '0;
                beat_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic. Handshake and write enable are held off while reset is
    // asserted so an in-flight beat is never written.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        dbg_ready_o = 1'b0;
        cpu_stall_o = 1'b0;
        if (rst_ni) begin
            case (state_q)
                S_CPU: begin
                    if (grant_dbg) begin
                        mem_we_o    = dbg_we_i;
                        mem_addr_o  = dbg_addr_i;
                        mem_wdata_o = dbg_wdata_i;
                        dbg_ready_o = 1'b1;
                        cpu_stall_o = cpu_req;
                    end else begin
                        mem_we_o = cpu_we_i;
                    end
                end
                S_DBG: begin
                    mem_we_o    = dbg_we_i & dbg_valid_i;
                    mem_addr_o  = dbg_addr_i;
                    mem_wdata_o = dbg_wdata_i;
                    dbg_ready_o = dbg_valid_i;
                    cpu_stall_o = cpu_req;
                end
                default: begin
                    mem_we_o = 1'b0;
                end
            endcase
        end
    end

    assign read_beat = dbg_valid_i & dbg_ready_o & ~dbg_we_i;

    // Debug read response: one-cycle pulse, data held until the next read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= read_beat;
            if (read_beat) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    assign dbg_rvalid_o = rvalid_q;
    assign dbg_rdata_o  = rdata_q;
    assign cpu_rdata_o  = mem_rdata_i;
    assign dbg_owner_o  = (state_q == S_DBG);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_valid;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ready;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        dbg_owner;

    int n_chk  = 0;
    int n_fail = 0;
    int wr88   = 0;
    int base88;

    logic [31:0] exp_q[$];
    logic [31:0] mem [0:255] = '{default: 32'h0};

    dmem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(8), .BURST(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cpu_re_i     (cpu_re),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_stall_o  (cpu_stall),
        .dbg_valid_i  (dbg_valid),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_ready_o  (dbg_ready),
        .dbg_rvalid_o (dbg_rvalid),
        .dbg_rdata_o  (dbg_rdata),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .dbg_owner_o  (dbg_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple word-addressed dmem behind the port.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            if (mem_addr == 32'h88) wr88 <= wr88 + 1;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; consume a scoreboard entry for any read response.
    task automatic tick();
        @(posedge clk);
        #1;
        if (dbg_rvalid === 1'b1) begin
            if (exp_q.size() == 0) chk1("rvalid_spurious", dbg_rvalid, 1'b0);
            else chk32("dbg_rdata", dbg_rdata, exp_q.pop_front());
        end
    endtask

    task automatic dbg_drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        dbg_valid = v;
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = d;
    endtask

    task automatic cpu_drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        dbg_drive(1'b1, 1'b1, 32'h80, 32'h1234);

        // Reset held: nothing granted, nothing written.
        repeat (3) begin
            #1;
            chk1("rst_stall", cpu_stall, 1'b0);
            chk1("rst_ready", dbg_ready, 1'b0);
            chk1("rst_mem_we", mem_we, 1'b0);
            chk1("rst_rvalid", dbg_rvalid, 1'b0);
            chk1("rst_owner", dbg_owner, 1'b0);
            tick();
        end
        rst_n = 1'b1;

        // Preload through the debug port with the CPU idle.
        dbg_drive(1'b1, 1'b1, 32'h80, 32'hDEADBEEF);
        #1;
        chk1("pre_ready", dbg_ready, 1'b1);
        chk1("pre_mem_we", mem_we, 1'b1);
        tick();
        dbg_drive(1'b1, 1'b1, 32'h88, 32'h55);
        tick();
        dbg_drive(1'b0, 1'b0, 32'h0, 32'h0);

        // CPU load.
        cpu_drive(1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        chk32("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk1("t1_stall", cpu_stall, 1'b0);
        chk1("t1_ready", dbg_ready, 1'b0);
        chk1("t1_rvalid", dbg_rvalid, 1'b0);
        tick();

        // Debug write then read with the CPU idle.
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        dbg_drive(1'b1, 1'b1, 32'h84, 32'h11);
        #1;
        chk1("t2_wr_ready", dbg_ready, 1'b1);
        chk1("t2_wr_stall", cpu_stall, 1'b0);
        tick();
        dbg_drive(1'b1, 1'b0, 32'h84, 32'h0);
        #1;
        chk1("t2_rd_ready", dbg_ready, 1'b1);
        chk1("t2_rd_stall", cpu_stall, 1'b0);
        exp_q.push_back(32'h11);
        tick();
        chk1("t2_rvalid", dbg_rvalid, 1'b1);
        dbg_drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("t2_stall_after", cpu_stall, 1'b0);
        tick();
        chk1("t2_rvalid_pulse", dbg_rvalid, 1'b0);

        // Starvation: CPU loads every cycle, debug read held.
        cpu_drive(1'b1, 1'b0, 32'h80, 32'h0);
        dbg_drive(1'b1, 1'b0, 32'h90, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk1("t3_refused", dbg_ready, 1'b0);
            chk1("t3_stall_refused", cpu_stall, 1'b0);
            chk32("t3_port_cpu", mem_addr, 32'h80);
            tick();
        end
        #1;
        chk1("t3_forced_ready", dbg_ready, 1'b1);
        chk1("t3_forced_stall", cpu_stall, 1'b1);
        chk32("t3_forced_addr", mem_addr, 32'h90);
        chk1("t3_owner_before", dbg_owner, 1'b0);
        exp_q.push_back(32'h0);
        tick();
        chk1("t3_owner", dbg_owner, 1'b1);
        chk1("t3_rvalid", dbg_rvalid, 1'b1);
        dbg_drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("t3_exit_ready", dbg_ready, 1'b0);
        chk1("t3_exit_stall", cpu_stall, 1'b1);
        tick();
        chk1("t3_owner_drop", dbg_owner, 1'b0);

        // Starvation followed by 6 back-to-back debug writes.
        dbg_drive(1'b1, 1'b1, 32'h100, 32'hA0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk1("t4_refused", dbg_ready, 1'b0);
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            dbg_drive(1'b1, 1'b1, 32'h100 + 32'(4 * b), 32'hA0 + 32'(b));
            #1;
            chk1("t4_beat_ready", dbg_ready, 1'b1);
            chk1("t4_beat_stall", cpu_stall, 1'b1);
            chk1("t4_beat_we", mem_we, 1'b1);
            chk32("t4_beat_addr", mem_addr, 32'h100 + 32'(4 * b));
            tick();
            chk1("t4_owner", dbg_owner, (b < 3));
        end
        dbg_drive(1'b1, 1'b1, 32'h110, 32'hA4);
        #1;
        chk1("t4_resume_ready", dbg_ready, 1'b0);
        chk1("t4_resume_stall", cpu_stall, 1'b0);
        chk32("t4_resume_addr", mem_addr, 32'h80);
        tick();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("t4_idle_ready4", dbg_ready, 1'b1);
        tick();
        dbg_drive(1'b1, 1'b1, 32'h114, 32'hA5);
        #1;
        chk1("t4_idle_ready5", dbg_ready, 1'b1);
        chk1("t4_idle_stall", cpu_stall, 1'b0);
        tick();
        dbg_drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            chk32("t4_mem", mem[8'h40 + 8'(k)], 32'hA0 + 32'(k));
        end

        // CPU store arriving during a forced burst.
        base88 = wr88;
        cpu_drive(1'b1, 1'b0, 32'h80, 32'h0);
        dbg_drive(1'b1, 1'b0, 32'h84, 32'h0);
        repeat (8) tick();
        #1;
        chk1("t5_forced_ready", dbg_ready, 1'b1);
        exp_q.push_back(32'h11);
        tick();
        cpu_drive(1'b0, 1'b1, 32'h88, 32'hAA);
        for (int b = 0; b < 3; b++) begin
            #1;
            chk1("t5_stall", cpu_stall, 1'b1);
            chk1("t5_ready", dbg_ready, 1'b1);
            chk1("t5_no_store", mem_we, 1'b0);
            chk32("t5_mem88_held", mem[8'h22], 32'h55);
            exp_q.push_back(32'h11);
            tick();
        end
        chk1("t5_owner_drop", dbg_owner, 1'b0);
        dbg_drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("t5_store_stall", cpu_stall, 1'b0);
        chk1("t5_store_we", mem_we, 1'b1);
        chk32("t5_store_addr", mem_addr, 32'h88);
        chk32("t5_store_data", mem_wdata, 32'hAA);
        tick();
        chk32("t5_mem88", mem[8'h22], 32'hAA);
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk32("t5_write_once", wr88 - base88, 32'd1);

        // Asynchronous reset in the middle of a burst.
        cpu_drive(1'b1, 1'b0, 32'h80, 32'h0);
        dbg_drive(1'b1, 1'b0, 32'h80, 32'h0);
        repeat (8) tick();
        exp_q.push_back(32'hDEADBEEF);
        tick();
        chk1("t6_rvalid", dbg_rvalid, 1'b1);
        chk1("t6_owner", dbg_owner, 1'b1);
        dbg_drive(1'b1, 1'b1, 32'h8C, 32'h77);
        #1;
        chk1("t6_inflight_we", mem_we, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_rvalid", dbg_rvalid, 1'b0);
        chk1("t6_rst_owner", dbg_owner, 1'b0);
        chk1("t6_rst_we", mem_we, 1'b0);
        chk1("t6_rst_ready", dbg_ready, 1'b0);
        chk1("t6_rst_stall", cpu_stall, 1'b0);
        tick();
        chk32("t6_mem8c", mem[8'h23], 32'h0);
        rst_n = 1'b1;
        dbg_drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("t6_cpu_stall", cpu_stall, 1'b0);
        chk32("t6_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk1("t6_owner_after", dbg_owner, 1'b0);
        tick();
        // Counters cleared: a fresh starvation takes the full 8 refusals.
        dbg_drive(1'b1, 1'b0, 32'h84, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk1("t6_refused", dbg_ready, 1'b0);
            tick();
        end
        #1;
        chk1("t6_forced_ready", dbg_ready, 1'b1);
        exp_q.push_back(32'h11);
        tick();
        dbg_drive(1'b0, 1'b0, 32'h0, 32'h0);
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
